coffee_brew_ctrl: RTL
=====================

Name: coffee_brew_ctrl

Overview:
Downstream stage of the vending FSM. Consumes the one-cycle COFFEE pulse and runs a timed brew sequence: grind, heat, pour, done. Tracks water level and bean doses, and feeds WATER[4:0] and BEANS back to the vending FSM as its resource inputs. Drives the grinder, heater and pump actuators.

Parameters:
GRIND_CYCLES, 4, cycles GRINDER is held high (legal range 1..255)
HEAT_CYCLES, 8, cycles HEATER is held high (1..255)
POUR_CYCLES, 6, cycles PUMP is held high (1..255)
WATER_PER_CUP, 2, water units consumed per cup (1..31)
WATER_MAX, 31, water level after reset or refill (≤31)
BEAN_DOSES, 10, bean doses after reset or refill (1..255)

Ports:
clk  in  1  system clock; all state changes on the rising edge
rst  in  1  synchronous reset, active-high
COFFEE  in  1  brew request; one-cycle pulse from the vending FSM
REFILL_WATER  in  1  operator water refill, level-sampled
REFILL_BEANS  in  1  operator bean refill, level-sampled
WATER  out  5  current water level, registered
BEANS  out  1  high when bean dose count is nonzero, registered
GRINDER  out  1  grinder enable
HEATER  out  1  heater enable
PUMP  out  1  pump enable
BUSY  out  1  high in every state except IDLE
DONE  out  1  one-cycle pulse when the cup is complete

Behaviour:
- Reset (rst=1 at an edge) forces the following, taking priority over everything else, including mid-brew:
  - state=IDLE, timer=0
  - water=WATER_MAX, beans=BEAN_DOSES
  - GRINDER=HEATER=PUMP=BUSY=DONE=0
  - A brew in progress is abandoned with no resource deduction.
- All outputs are registered Moore outputs decoded from state. No combinational path from any input to any output.
- States and transitions:
  - IDLE:
    - COFFEE=1 and water≥WATER_PER_CUP and beans≠0 → GRIND, timer loaded with GRIND_CYCLES-1.
    - COFFEE=1 with insufficient resources is ignored; remain in IDLE.
  - GRIND: GRINDER=1. At timer==0 → HEAT (timer=HEAT_CYCLES-1) and beans decremented by 1.
  - HEAT: HEATER=1. At timer==0 → POUR (timer=POUR_CYCLES-1).
  - POUR: PUMP=1. At timer==0 → DONE_ST and water decremented by WATER_PER_CUP, saturating at 0.
  - DONE_ST: DONE=1 for exactly one cycle, then → IDLE.
- Timer is an 8-bit down-counter, decremented each cycle while nonzero in GRIND, HEAT and POUR.
- Latency: COFFEE sampled at edge N gives:
  - GRINDER high for edges N+1..N+G
  - HEATER high for the next H cycles
  - PUMP high for the next P cycles
  - DONE high one cycle after that
  - Total busy = G+H+P+1 cycles.
- COFFEE while BUSY=1 is ignored. Requests are not queued.
- Refill is honoured only in IDLE:
  - REFILL_WATER=1 sets water=WATER_MAX.
  - REFILL_BEANS=1 sets beans=BEAN_DOSES.
  - Both may occur in the same cycle.
  - Refill is ignored while BUSY.
- Simultaneous refill and COFFEE in IDLE: the refill wins and COFFEE is dropped; state stays IDLE.
- Water saturates at 0 and never wraps. The bean counter never decrements from 0 because the start check guarantees beans≠0.
- WATER and BEANS update on the same edge as the counter change, so the vending FSM sees new values one cycle after the deduction edge.
- Unreachable state encodings recover to IDLE with all actuators off.

Decomposition:
- Shared package/include holds:
  - State encoding constants: IDLE=3'd0, GRIND=3'd1, HEAT=3'd2, POUR=3'd3, DONE_ST=3'd4
  - Timer width constant (8)
  - Water width constant (5), shared with the vending FSM's WATER port
- Optional sub-module brew_timer: 8-bit loadable down-counter with load, value and zero-flag ports, reused for each phase.
- State register, next-state logic and resource counters stay in coffee_brew_ctrl.

Test Plan:
- Reset, then idle 5 cycles → WATER=31, BEANS=1, all actuators, BUSY and DONE=0.
- One COFFEE pulse with defaults:
  - GRINDER high exactly 4 cycles, then HEATER 8, then PUMP 6, then DONE high 1 cycle.
  - BUSY high for 19 cycles.
  - Afterwards WATER=29 and internal bean count=9.
- 10 back-to-back cups (COFFEE each time DONE falls) → BEANS=0 after the 10th.
  - An 11th COFFEE is ignored: BUSY stays 0.
  - Then REFILL_BEANS in IDLE → BEANS=1, and the next COFFEE brews.
- Extra COFFEE pulses during HEAT and POUR → no restart, no second DONE, deduction happens once.
- Water drain: WATER_PER_CUP=2, refill water, run 15 cups → WATER=1.
  - The next COFFEE is ignored.
  - REFILL_WATER with COFFEE in the same cycle → WATER=31, state stays IDLE.
- rst asserted in the 3rd cycle of POUR → next cycle PUMP=0, BUSY=0, WATER=31, BEANS=1, no DONE pulse.

Source files
------------

// File: rtl/coffee_brew_ctrl_pkg.sv
// coffee_brew_ctrl_pkg: state encodings, widths and helpers shared by the brew controller.
package coffee_brew_ctrl_pkg;
  localparam int TIMER_W = 8;
  localparam int WATER_W = 5;
  localparam int BEAN_W  = 8;
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_GRIND = 3'd1;
  localparam logic [2:0] S_HEAT  = 3'd2;
  localparam logic [2:0] S_POUR  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  function automatic logic [WATER_W-1:0] sat_sub(input logic [WATER_W-1:0] a, input logic [WATER_W-1:0] b);
    return (a < b) ? '0 : a - b;
  endfunction
endpackage

// File: rtl/coffee_brew_ctrl_timer.sv
// coffee_brew_ctrl_timer: loadable down-counter shared by the grind, heat and pour phases.
module coffee_brew_ctrl_timer
  import coffee_brew_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               i_load,
  input  logic [TIMER_W-1:0] i_value,
  input  logic               i_en,
  output logic               o_zero
);
  logic [TIMER_W-1:0] r_cnt;
  always_ff @(posedge clk) begin
    if (rst) r_cnt <= '0;
    else if (i_load) r_cnt <= i_value;
    else if (i_en && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
  end
  assign o_zero = (r_cnt == '0);
endmodule

// File: rtl/coffee_brew_ctrl.sv
// coffee_brew_ctrl: timed grind/heat/pour brew sequencer with water and bean accounting.
module coffee_brew_ctrl
  import coffee_brew_ctrl_pkg::*;
#(
  parameter int unsigned GRIND_CYCLES  = 4,
  parameter int unsigned HEAT_CYCLES   = 8,
  parameter int unsigned POUR_CYCLES   = 6,
  parameter int unsigned WATER_PER_CUP = 2,
  parameter int unsigned WATER_MAX     = 31,
  parameter int unsigned BEAN_DOSES    = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               COFFEE,
  input  logic               REFILL_WATER,
  input  logic               REFILL_BEANS,
  output logic [WATER_W-1:0] WATER,
  output logic               BEANS,
  output logic               GRINDER,
  output logic               HEATER,
  output logic               PUMP,
  output logic               BUSY,
  output logic               DONE
);
  localparam logic [WATER_W-1:0] W_MAX = WATER_W'(WATER_MAX);
  localparam logic [WATER_W-1:0] W_CUP = WATER_W'(WATER_PER_CUP);
  localparam logic [BEAN_W-1:0]  B_MAX = BEAN_W'(BEAN_DOSES);
  logic [2:0]         r_state, w_next;
  logic [WATER_W-1:0] r_water, w_water;
  logic [BEAN_W-1:0]  r_beans, w_beans;
  logic               r_beans_nz, r_grinder, r_heater, r_pump, r_busy, r_done;
  logic               w_load, w_zero, w_en, w_refill;
  logic [TIMER_W-1:0] w_load_val;
  assign w_en     = (r_state == S_GRIND) || (r_state == S_HEAT) || (r_state == S_POUR);
  assign w_refill = REFILL_WATER || REFILL_BEANS;
  // Refill has priority over a simultaneous brew request in IDLE.
  always_comb begin
    w_next     = S_IDLE;
    w_load     = 1'b0;
    w_load_val = '0;
    w_water    = r_water;
    w_beans    = r_beans;
    case (r_state)
      S_IDLE: begin
        w_next  = (!w_refill && COFFEE && r_water >= W_CUP && r_beans != '0) ? S_GRIND : S_IDLE;
        w_load  = (w_next == S_GRIND);
        w_load_val = TIMER_W'(GRIND_CYCLES - 1);
        w_water = REFILL_WATER ? W_MAX : r_water;
        w_beans = REFILL_BEANS ? B_MAX : r_beans;
      end
      S_GRIND: begin
        w_next  = w_zero ? S_HEAT : S_GRIND;
        w_load  = w_zero;
        w_load_val = TIMER_W'(HEAT_CYCLES - 1);
        w_beans = w_zero ? r_beans - 1'b1 : r_beans;
      end
      S_HEAT: begin
        w_next  = w_zero ? S_POUR : S_HEAT;
        w_load  = w_zero;
        w_load_val = TIMER_W'(POUR_CYCLES - 1);
      end
      S_POUR: begin
        w_next  = w_zero ? S_DONE : S_POUR;
        w_water = w_zero ? sat_sub(r_water, W_CUP) : r_water;
      end
      default: w_next = S_IDLE;
    endcase
  end
  coffee_brew_ctrl_timer u_timer (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_value (w_load_val),
    .i_en    (w_en),
    .o_zero  (w_zero)
  );
  // Outputs are registered from the next state so they align with r_state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_water    <= W_MAX;
      r_beans    <= B_MAX;
      r_beans_nz <= (B_MAX != '0);
      r_grinder  <= 1'b0;
      r_heater   <= 1'b0;
      r_pump     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_water    <= w_water;
      r_beans    <= w_beans;
      r_beans_nz <= (w_beans != '0);
      r_grinder  <= (w_next == S_GRIND);
      r_heater   <= (w_next == S_HEAT);
      r_pump     <= (w_next == S_POUR);
      r_busy     <= (w_next != S_IDLE);
      r_done     <= (w_next == S_DONE);
    end
  end
  assign WATER   = r_water;
  assign BEANS   = r_beans_nz;
  assign GRINDER = r_grinder;
  assign HEATER  = r_heater;
  assign PUMP    = r_pump;
  assign BUSY    = r_busy;
  assign DONE    = r_done;
endmodule
